// File: rtl/pid_sched_pkg.sv
// Shared types and helpers for the time-multiplexed PID loop scheduler.
package pid_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNAP  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4
    } pid_sched_state_e;

    localparam logic [1:0] CFG_SETPOINT = 2'd0;
    localparam logic [1:0] CFG_KP       = 2'd1;
    localparam logic [1:0] CFG_KI       = 2'd2;
    localparam logic [1:0] CFG_KD       = 2'd3;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned SEL_W  = 5;

    // Returns {found, index} of the lowest set mask bit above cur (or at/above 0 when first).
    function automatic logic [SEL_W-1:0] next_enabled(
        input logic [MAX_CH-1:0] mask,
        input logic [3:0]        cur,
        input logic              first
    );
        logic [SEL_W-1:0] res;
        res = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (4'(i) > cur))) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Free-running prescaler: counts 0..clk_prescaler and flags the compare cycle.
module pid_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clk_prescaler,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // A prescaler below the current count lets the counter run on and wrap at 16 bits.
    assign tick = (cnt_q == clk_prescaler);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pid_loop_scheduler.sv
// Sweeps one shared PID core across NUM_CH loops, one update per enabled loop per tick,
// with a per-loop gain/setpoint bank and a feedback snapshot taken at sweep start.
module pid_loop_scheduler
    import pid_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DW     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [15:0]                clk_prescaler,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [1:0]                 cfg_sel,
    input  logic [DW-1:0]              cfg_wdata,
    input  logic [NUM_CH*DW-1:0]       feedback,
    output logic                       pid_start,
    output logic [DW-1:0]              pid_setpoint,
    output logic [DW-1:0]              pid_feedback,
    output logic [DW-1:0]              pid_kp,
    output logic [DW-1:0]              pid_ki,
    output logic [DW-1:0]              pid_kd,
    input  logic                       pid_done,
    input  logic [DW-1:0]              pid_result,
    output logic [NUM_CH*DW-1:0]       ctrl_out,
    output logic [NUM_CH-1:0]          ctrl_valid,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int unsigned CW = $clog2(NUM_CH);

    pid_sched_state_e state_q;
    pid_sched_state_e state_d;

    logic [CW-1:0]        ch_q;
    logic [CW-1:0]        ch_d;
    logic [NUM_CH-1:0]    mask_q;
    logic [DW-1:0]        fb_snap_q [NUM_CH];
    logic [DW-1:0]        sp_q      [NUM_CH];
    logic [DW-1:0]        kp_q      [NUM_CH];
    logic [DW-1:0]        ki_q      [NUM_CH];
    logic [DW-1:0]        kd_q      [NUM_CH];
    logic [DW-1:0]        result_q;
    logic [DW-1:0]        op_sp_q;
    logic [DW-1:0]        op_fb_q;
    logic [DW-1:0]        op_kp_q;
    logic [DW-1:0]        op_ki_q;
    logic [DW-1:0]        op_kd_q;
    logic [NUM_CH*DW-1:0] ctrl_out_q;
    logic [NUM_CH-1:0]    ctrl_valid_q;
    logic [NUM_CH-1:0]    ctrl_valid_d;
    logic                 pid_start_q;
    logic                 pid_start_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic                 load_ops;
    logic [DW-1:0]        fb_sel;
    logic                 tick;
    logic [SEL_W-1:0]     sel_first;
    logic [SEL_W-1:0]     sel_next;

    pid_tick_gen u_tick_gen (
        .clk           (clk),
        .rst           (rst),
        .clk_prescaler (clk_prescaler),
        .tick          (tick)
    );

    assign sel_first = next_enabled(16'(ch_enable), 4'd0, 1'b1);
    assign sel_next  = next_enabled(16'(mask_q), 4'(ch_q), 1'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                // Empty mask ends the sweep without touching the core.
                if (sel_first[SEL_W-1]) begin
                    state_d = ST_ISSUE;
                    ch_d    = CW'(sel_first[3:0]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pid_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sel_next[SEL_W-1]) begin
                    state_d = ST_ISSUE;
                    ch_d    = CW'(sel_next[3:0]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pid_start_d  = (state_d == ST_ISSUE);
        busy_d       = (state_d != ST_IDLE);
        load_ops     = (state_d == ST_ISSUE);
        ctrl_valid_d = '0;
        overrun_d    = overrun_q;
        // The snapshot is written on the same edge as the first operand load, so bypass it.
        fb_sel = fb_snap_q[ch_d];
        if (state_q == ST_SNAP) begin
            fb_sel = feedback[32'(ch_d)*DW +: DW];
        end
        if (state_q == ST_WRITE) begin
            ctrl_valid_d[ch_q] = 1'b1;
        end
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sp_q[i] <= '0;
                kp_q[i] <= '0;
                ki_q[i] <= '0;
                kd_q[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
            case (cfg_sel)
                CFG_SETPOINT: sp_q[cfg_ch] <= cfg_wdata;
                CFG_KP:       kp_q[cfg_ch] <= cfg_wdata;
                CFG_KI:       ki_q[cfg_ch] <= cfg_wdata;
                CFG_KD:       kd_q[cfg_ch] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                fb_snap_q[i] <= '0;
            end
        end else if (state_q == ST_SNAP) begin
            mask_q <= ch_enable;
            for (int i = 0; i < NUM_CH; i++) begin
                fb_snap_q[i] <= feedback[i*DW +: DW];
            end
        end
    end

    // Operands stay frozen from the start pulse until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_sp_q <= '0;
            op_fb_q <= '0;
            op_kp_q <= '0;
            op_ki_q <= '0;
            op_kd_q <= '0;
        end else if (load_ops) begin
            op_sp_q <= sp_q[ch_d];
            op_fb_q <= fb_sel;
            op_kp_q <= kp_q[ch_d];
            op_ki_q <= ki_q[ch_d];
            op_kd_q <= kd_q[ch_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q     <= '0;
            ctrl_out_q   <= '0;
            ctrl_valid_q <= '0;
            pid_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if ((state_q == ST_WAIT) && pid_done) begin
                result_q <= pid_result;
            end
            if (state_q == ST_WRITE) begin
                ctrl_out_q[32'(ch_q)*DW +: DW] <= result_q;
            end
            ctrl_valid_q <= ctrl_valid_d;
            pid_start_q  <= pid_start_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign pid_start    = pid_start_q;
    assign pid_setpoint = op_sp_q;
    assign pid_feedback = op_fb_q;
    assign pid_kp       = op_kp_q;
    assign pid_ki       = op_ki_q;
    assign pid_kd       = op_kd_q;
    assign ctrl_out     = ctrl_out_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Randomized bench for pid_loop_scheduler against a transaction-level sweep model.
module tb_pid_loop_scheduler;
    import pid_sched_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = $clog2(NUM_CH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [NUM_CH-1:0]    ch_enable;
    logic [15:0]          clk_prescaler;
    logic                 cfg_we;
    logic [CW-1:0]        cfg_ch;
    logic [1:0]           cfg_sel;
    logic [DW-1:0]        cfg_wdata;
    logic [NUM_CH*DW-1:0] feedback;
    logic                 pid_start;
    logic [DW-1:0]        pid_setpoint, pid_feedback, pid_kp, pid_ki, pid_kd;
    logic                 pid_done;
    logic [DW-1:0]        pid_result;
    logic [NUM_CH*DW-1:0] ctrl_out;
    logic [NUM_CH-1:0]    ctrl_valid;
    logic                 busy;
    logic                 overrun;
    logic                 overrun_clr;

    pid_loop_scheduler #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .ch_enable     (ch_enable),
        .clk_prescaler (clk_prescaler),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_sel       (cfg_sel),
        .cfg_wdata     (cfg_wdata),
        .feedback      (feedback),
        .pid_start     (pid_start),
        .pid_setpoint  (pid_setpoint),
        .pid_feedback  (pid_feedback),
        .pid_kp        (pid_kp),
        .pid_ki        (pid_ki),
        .pid_kd        (pid_kd),
        .pid_done      (pid_done),
        .pid_result    (pid_result),
        .ctrl_out      (ctrl_out),
        .ctrl_valid    (ctrl_valid),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int scyc     = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Stand-in PID arithmetic; any mixing of all five operands will do.
    function automatic logic [DW-1:0] core_fn(input logic [5*DW-1:0] ops);
        logic [DW-1:0] sp, fb, kp, ki, kd;
        {sp, fb, kp, ki, kd} = ops;
        return sp + (fb ^ kp) + ki - kd;
    endfunction

    // ---------------- reference model state ----------------
    typedef struct { int cyc; int ch; logic [DW-1:0] fb; } start_t;
    typedef struct { int cyc; int ch; logic [DW-1:0] val; } valid_t;

    start_t               sq[$];
    valid_t               vq[$];
    logic [DW-1:0]        sp_m[NUM_CH], kp_m[NUM_CH], ki_m[NUM_CH], kd_m[NUM_CH];
    logic [NUM_CH*DW-1:0] ctrl_m;
    int                   presc_m  = 0;
    int                   lat      = 1;
    bit                   have_sw  = 0;
    int                   t_sw     = 0;
    int                   idle_c   = 0;
    bit                   ov_m     = 0;
    bit                   prev_rst = 0;
    logic [5*DW-1:0]      hold_ops;
    int                   hold_from = 0;
    int                   hold_to   = -1;

    task automatic monitor_cycle();
        bit              busy_m, tick_m, st_exp;
        logic [NUM_CH-1:0] vexp;
        logic [5*DW-1:0] ops_now, exp_ops;
        start_t          s;
        valid_t          v;
        int              k;
        ops_now = {pid_setpoint, pid_feedback, pid_kp, pid_ki, pid_kd};
        if (prev_rst) check_eq("rst_operands", ops_now, '0);
        // Sweep layout: start k at T+2+k*(lat+2), idle after the last write.
        if (have_sw && cyc == t_sw + 1) begin
            k = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_enable[i]) begin
                    s.cyc = t_sw + 2 + k * (lat + 2);
                    s.ch  = i;
                    s.fb  = feedback[i*DW +: DW];
                    sq.push_back(s);
                    k++;
                end
            end
            idle_c = t_sw + 2 + k * (lat + 2);
        end
        busy_m = have_sw && (cyc >= t_sw + 1) && (cyc < idle_c);
        tick_m = (cyc % (presc_m + 1)) == presc_m;
        check_eq("busy", busy, busy_m);
        check_eq("overrun", overrun, ov_m);
        if (tick_m && busy_m) ov_m = 1;
        else if (overrun_clr) ov_m = 0;
        if (tick_m && !busy_m && enable) begin
            have_sw = 1;
            t_sw    = cyc;
            idle_c  = cyc + 2;
        end

        while (sq.size() > 0 && sq[0].cyc < cyc) sq.delete(0);
        st_exp = (sq.size() > 0) && (sq[0].cyc == cyc);
        check_eq("pid_start", pid_start, st_exp);
        if (st_exp) begin
            s = sq[0];
            sq.delete(0);
            exp_ops = {sp_m[s.ch], s.fb, kp_m[s.ch], ki_m[s.ch], kd_m[s.ch]};
            check_eq($sformatf("operands_ch%0d", s.ch), ops_now, exp_ops);
            hold_ops  = exp_ops;
            hold_from = cyc + 1;
            hold_to   = cyc + lat;
            v.cyc = cyc + lat + 2;
            v.ch  = s.ch;
            v.val = core_fn(exp_ops);
            vq.push_back(v);
        end else if (cyc >= hold_from && cyc <= hold_to) begin
            check_eq("operand_hold", ops_now, hold_ops);
        end

        while (vq.size() > 0 && vq[0].cyc < cyc) vq.delete(0);
        vexp = '0;
        if (vq.size() > 0 && vq[0].cyc == cyc) begin
            v = vq[0];
            vq.delete(0);
            vexp[v.ch] = 1'b1;
            ctrl_m[v.ch*DW +: DW] = v.val;
        end
        check_eq("ctrl_valid", ctrl_valid, vexp);
        check_eq("ctrl_out", ctrl_out, ctrl_m);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc     = 0;
            have_sw = 0;
            ov_m    = 0;
            ctrl_m  = '0;
            hold_to = -1;
            sq.delete();
            vq.delete();
            for (int i = 0; i < NUM_CH; i++) begin
                sp_m[i] = '0; kp_m[i] = '0; ki_m[i] = '0; kd_m[i] = '0;
            end
            prev_rst = 1;
        end else begin
            monitor_cycle();
            prev_rst = 0;
            cyc++;
        end
    end

    // ---------------- PID core model ----------------
    initial begin
        logic [DW-1:0] r;
        pid_done   = 1'b0;
        pid_result = '0;
        forever begin
            @(negedge clk);
            if (pid_start) begin
                r = core_fn({pid_setpoint, pid_feedback, pid_kp, pid_ki, pid_kd});
                repeat (lat) @(posedge clk);
                #1;
                pid_done   = 1'b1;
                pid_result = r;
                @(posedge clk);
                #1;
                pid_done   = 1'b0;
                pid_result = DW'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit fb_rand  = 0;
    bit clr_rand = 0;

    task automatic step();
        @(posedge clk);
        #1;
        scyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            if (fb_rand) begin
                for (int i = 0; i < NUM_CH; i++) feedback[i*DW +: DW] = DW'($urandom);
            end
            if (clr_rand) overrun_clr = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    task automatic reset_dut(input int p, input int l, input logic [NUM_CH-1:0] mask);
        rst         = 1'b1;
        enable      = 1'b0;
        cfg_we      = 1'b0;
        overrun_clr = 1'b0;
        fb_rand     = 0;
        clr_rand    = 0;
        repeat (10) step();
        clk_prescaler = 16'(p);
        presc_m       = p;
        lat           = l;
        ch_enable     = mask;
        rst           = 1'b0;
        scyc          = 0;
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] sel, input logic [DW-1:0] val);
        cfg_we    = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_sel   = sel;
        cfg_wdata = val;
        case (sel)
            CFG_SETPOINT: sp_m[ch] = val;
            CFG_KP:       kp_m[ch] = val;
            CFG_KI:       ki_m[ch] = val;
            default:      kd_m[ch] = val;
        endcase
        step();
        cfg_we = 1'b0;
    endtask

    task automatic config_all();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int s = 0; s < 4; s++) cfg_write(ch, 2'(s), DW'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; ch_enable = '0; clk_prescaler = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
        feedback = '0; overrun_clr = 1'b0;

        // Full mask, 1-cycle core, tick every 10 cycles.
        reset_dut(9, 1, 4'b1111);
        config_all();
        enable = 1'b1; fb_rand = 1;
        run(80);
        enable = 1'b0;
        run(20);

        // Sparse mask: only channels 1 and 3.
        reset_dut(15, 1, 4'b1010);
        config_all();
        enable = 1'b1; fb_rand = 1;
        run(70);

        // Empty mask: SNAP then straight back to IDLE.
        reset_dut(11, 2, 4'b0000);
        config_all();
        enable = 1'b1;
        run(50);

        // Tick every cycle with a slow core: overrun set and clear contention.
        reset_dut(0, 5, 4'b1111);
        config_all();
        enable = 1'b1; clr_rand = 1; fb_rand = 1;
        run(60);
        enable = 1'b0;
        run(30);
        clr_rand = 0; overrun_clr = 1'b1;
        run(2);
        overrun_clr = 1'b0;
        run(3);

        // Kp write to channel 2 while it waits on the core (WAIT spans cycles 116..120).
        reset_dut(99, 5, 4'b1111);
        config_all();
        enable = 1'b1; fb_rand = 1;
        run(117 - scyc);
        cfg_write(2, CFG_KP, 16'h0100);
        run(150);

        // Randomized configurations.
        for (int it = 0; it < 4; it++) begin
            reset_dut($urandom_range(8, 30), $urandom_range(1, 4), NUM_CH'($urandom));
            config_all();
            enable = 1'b1; fb_rand = 1; clr_rand = 1;
            run(120);
        end

        // Reset while channel 0 waits on the core; its late done must be ignored.
        reset_dut(19, 6, 4'b1111);
        config_all();
        enable = 1'b1;
        run(23 - scyc);
        rst = 1'b1;
        step();
        rst = 1'b0; enable = 1'b0; scyc = 0;
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_loop_scheduler.md
# pid_loop_scheduler

Time-multiplexes one `pid_controller` datapath across `NUM_CH` independent control loops. A prescaler tick starts a sweep, and each enabled channel gets one PID update per sweep. The block holds a per-channel register bank for setpoint and gains, and snapshots every channel's feedback at the start of each sweep. It drives the shared PID core through a start/done handshake and stores each loop's control output.

## Interface
Parameters:
- `NUM_CH`, 4, number of loops (2..16)
- `DW`, 16, data width of setpoint, feedback, gains and control signal

Ports:
- `clk` input 1: system clock
- `rst` input 1: synchronous, active-high reset
- `enable` input 1: sweeps are allowed while high
- `ch_enable` input NUM_CH: per-channel participation mask, sampled at sweep start
- `clk_prescaler` input 16: tick period minus one
- `cfg_we` input 1: register-bank write strobe
- `cfg_ch` input $clog2(NUM_CH): channel to write
- `cfg_sel` input 2: field to write; 0 setpoint, 1 Kp, 2 Ki, 3 Kd
- `cfg_wdata` input DW: write data
- `feedback` input NUM_CH*DW: live feedback, channel i in bits [i*DW +: DW]
- `pid_start` output 1: one-cycle request to the PID core
- `pid_setpoint`, `pid_feedback`, `pid_kp`, `pid_ki`, `pid_kd` output DW each: operands, held stable from start until done
- `pid_done` input 1: PID result valid
- `pid_result` input DW: PID control value
- `ctrl_out` output NUM_CH*DW: latest control value per channel
- `ctrl_valid` output NUM_CH: one-cycle pulse when the matching `ctrl_out` slice updates
- `busy` output 1: sweep in progress
- `overrun` output 1: sticky flag, a tick arrived while busy
- `overrun_clr` input 1: clears `overrun`

## Operation
- Tick generator: counter runs 0..`clk_prescaler`, then wraps to 0.
  - `tick` pulses in the cycle the counter equals `clk_prescaler`.
  - Prescaler 0 gives a tick every cycle.
  - A prescaler change takes effect at the next compare. If the new value is below the current count, the counter wraps at 16 bits.
- FSM states: IDLE, SNAP, ISSUE, WAIT, WRITE.
- IDLE: on `tick && enable`, go to SNAP. A tick with `enable` low is dropped silently.
- SNAP: latch all `feedback` slices and `ch_enable`. Select the lowest enabled channel.
  - Empty mask: return to IDLE without issuing a start.
- ISSUE: drive the operands from the bank and the snapshot, assert `pid_start` for one cycle, then go to WAIT.
- WAIT: hold the operands. Go to WRITE on `pid_done`.
  - `pid_done` outside WAIT is ignored.
- WRITE: store the registered `pid_result` into `ctrl_out[ch]` and pulse `ctrl_valid[ch]`.
  - Advance to the next higher enabled channel and go to ISSUE.
  - If there is none, go to IDLE.
- `busy` is high in every state except IDLE.
- Overrun: a tick in any non-IDLE state sets `overrun` and is dropped. It is never queued.
  - If set and `overrun_clr` occur in the same cycle, set wins.
- Config writes are accepted in any state and take effect at the next ISSUE.
  - A write to the in-flight channel does not disturb the held operands.
- Arithmetic is the PID core's job. This block passes values through unmodified and performs no saturation.

## Timing
- Reset values:
  - FSM in IDLE; prescaler counter 0.
  - Bank, snapshot, operands and `ctrl_out` all 0.
  - `pid_start`, `ctrl_valid`, `busy` and `overrun` all 0.
- Cycle sequence from a tick in cycle T:
  - SNAP at T+1.
  - `pid_start` at T+2.
  - If `pid_done` arrives at cycle D: WRITE at D+1, and `ctrl_out`/`ctrl_valid` are visible at D+2.
  - Next `pid_start` at D+2.
- Minimum per-channel cost is 3 cycles, with the PID core returning done one cycle after start.
- Reset asserted mid-sweep: return to reset values on the next edge and discard any in-flight result. A later `pid_done` lands in IDLE and is ignored.

## Structure
- Package `pid_sched_pkg`:
  - State enum `pid_sched_state_e`.
  - `cfg_sel` localparams: `CFG_SETPOINT`, `CFG_KP`, `CFG_KI`, `CFG_KD`.
- Sub-module `pid_tick_gen`: prescaler counter with `clk`, `rst`, `clk_prescaler` in and `tick` out. It is reused by other loop blocks.
- Channel selection is a priority-encoder function in the package: next enabled index strictly greater than the current one.

## Test plan
- Reset, then prescaler 9, `enable` 1, mask 4'b1111, core model with 1-cycle done:
  - Ticks every 10 cycles.
  - 4 `pid_start` pulses per sweep, channels 0,1,2,3.
  - `ctrl_valid` pulses in order; `busy` low between sweeps.
- Mask 4'b1010: only channels 1 and 3 are issued. Mask 4'b0000: no `pid_start` and `busy` returns low 2 cycles after the tick.
- Prescaler 0 with a 5-cycle core latency: `overrun` sets on the first mid-sweep tick. It clears on `overrun_clr`, except in a cycle where a tick also arrives, where it stays 1.
- Write Kp=0x0100 to channel 2 while channel 2 is in WAIT:
  - The held `pid_kp` is unchanged.
  - Channel 2's next-sweep ISSUE shows 0x0100.
- Change channel 1 feedback during the sweep: `pid_feedback` for channel 1 equals the value sampled in SNAP.
- Assert `rst` during WAIT:
  - All outputs are 0 on the next cycle.
  - A late `pid_done` produces no `ctrl_valid`.
